rr_arbiter_4: RTL and testbench
===============================

# rr_arbiter_4

Four-requester round-robin arbiter that shares one resource among requesters 0..3. It drives the resource select through a 2-bit index and a one-hot grant. The one-hot grant is the 2-to-4 decode of that index, gated by `busy`. The grant is held until the owner releases it, the owner drops its request, or a hold limit expires. Fairness comes from a rotating priority pointer.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive cycles one grant may stay asserted; legal range 1..15.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  4  request per requester; level, held until served.
- `release`  in  1  current owner finished; sampled only while `busy`=1.
- `gnt`  out  4  one-hot grant; all-zero when idle.
- `gnt_idx`  out  2  index of current owner; 0 when idle.
- `busy`  out  1  high while a grant is asserted.
- `timeout`  out  1  one-cycle pulse: previous grant was revoked by the hold limit.

## Operation
- State: `busy` (IDLE=0 / GRANT=1), `ptr[1:0]` (highest-priority index), `cnt[3:0]` (cycles current grant has been asserted), all registered.
- Priority order from `ptr`: ptr, ptr+1, ptr+2, ptr+3, mod 4. The winner is the first set bit of `req` in that order.
- `gnt` = decode(`gnt_idx`) when `busy`=1, else 4'b0000. It is always one-hot or zero.
- IDLE:
  - If `req`≠0, the next cycle enters GRANT with `gnt_idx`=winner and `cnt`=1.
  - Otherwise stay in IDLE.
- GRANT, per cycle, the end condition is E = `release` | ~`req[gnt_idx]` | (`cnt`==HOLD_MAX).
  - E=0: hold `gnt_idx`, `cnt`++.
  - E=1: `ptr` ← `gnt_idx`+1 (3 wraps to 0), then re-arbitrate over the current `req` using the new pointer.
    - If a winner exists, the next cycle has `gnt_idx`=winner and `cnt`=1. This is a direct handover with no idle gap.
    - If no winner, the next cycle is IDLE with `gnt`=0.
  - The outgoing owner is last in the new order. It is re-granted only if it is the sole requester.
- `timeout`:
  - Next-cycle value = `busy` & (`cnt`==HOLD_MAX) & ~`release` & `req[gnt_idx]`.
  - `release` or a dropped request in the limit cycle takes precedence, and no pulse is produced.
- `ptr` changes only when a grant ends. It is not updated on entry from IDLE.

## Timing
- Reset values: `gnt`=0, `gnt_idx`=0, `busy`=0, `timeout`=0; internal `ptr`=0, `cnt`=0.
- Reset mid-grant: the cycle after `rst` is sampled high, all outputs are at reset values. `rst` overrides every other input.
- Request-to-grant latency: 1 cycle from the first edge where `req`≠0 in IDLE.
- Grant duration: at most HOLD_MAX cycles. A grant ending on E has its last asserted cycle in the cycle E is true. The next owner's `gnt` is asserted in the following cycle.
- HOLD_MAX=1: every grant lasts exactly 1 cycle. Requesters that stay high rotate every cycle.
- Inputs are sampled only at rising edges. `release` while idle is ignored.
- `timeout` is high in the first cycle after revocation, concurrent with the next grant or with idle.

## Test plan
- Reset and idle: `rst`=1 for 2 cycles with `req`=4'b1111 → `gnt`=0, `busy`=0, `timeout`=0 throughout. Release `rst` → the next cycle gives `gnt`=4'b0001, `gnt_idx`=0.
- Round-robin rotation: `req`=4'b1111, `release` pulsed in each grant's first cycle → `gnt` sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles with no gaps.
- Hold timeout, HOLD_MAX=8: `req`=4'b0101 held, `release`=0 → `gnt`=0001 for exactly 8 cycles. Then `gnt`=0100 with `timeout`=1 for that single cycle.
- Release versus limit: in the 8th grant cycle, assert `release`=1 → handover occurs and `timeout` stays 0.
- Sole requester and wrap: `req`=4'b1000, release after 3 cycles → `gnt`=1000, re-granted to index 3, and `ptr` wraps to 0. Then drop `req` to 0 → next cycle `busy`=0, `gnt`=0.
- Reset mid-operation: assert `rst` during the 4th cycle of a grant to index 2 → the next cycle gives all outputs 0. After release of `rst`, the pointer has restarted at 0, so `req`=4'b0110 grants index 1.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a per-grant hold limit.
// `rel` is the owner-release input (release is a reserved word).
module rr_arbiter_4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       rel,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state, state_n;
  logic [1:0] ptr, ptr_n;
  logic [3:0] cnt, cnt_n;
  logic [1:0] idx, idx_n;
  logic       timeout_n;

  logic       at_limit, end_grant;
  logic [1:0] ptr_adv;
  logic [2:0] win_idle, win_hand;

  // Returns {found, index} of the first set request starting at base.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] c;
    res = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      c = base + 2'(i - 1);
      if (r[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  always_comb begin
    at_limit  = (cnt == 4'(HOLD_MAX));
    end_grant = rel | ~req[idx] | at_limit;
    ptr_adv   = idx + 2'd1;
    win_idle  = pick(req, ptr);
    win_hand  = pick(req, ptr_adv);
    timeout_n = (state == GRANT) & at_limit & ~rel & req[idx];

    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    idx_n   = idx;

    unique case (state)
      IDLE: begin
        if (win_idle[2]) begin
          state_n = GRANT;
          idx_n   = win_idle[1:0];
          cnt_n   = 4'd1;
        end
      end
      GRANT: begin
        if (!end_grant) begin
          cnt_n = cnt + 4'd1;
        end else begin
          // Outgoing owner drops to last priority; hand over directly if anyone waits.
          ptr_n = ptr_adv;
          if (win_hand[2]) begin
            idx_n = win_hand[1:0];
            cnt_n = 4'd1;
          end else begin
            state_n = IDLE;
            idx_n   = '0;
            cnt_n   = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      idx     <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      timeout <= timeout_n;
    end
  end

  assign busy    = (state == GRANT);
  assign gnt_idx = idx;
  assign gnt     = busy ? (4'b0001 << idx) : 4'b0000;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed-vector scoreboard bench for rr_arbiter_4 (HOLD_MAX = 8).
module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       rel = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb[$];
  string      names[$];

  rr_arbiter_4 #(.HOLD_MAX(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input string nm, input logic r, input logic [3:0] q, input logic l,
                      input logic [3:0] g, input logic [1:0] i, input logic b, input logic t);
    @(negedge clk);
    rst = r;
    req = q;
    rel = l;
    sb.push_back({g, i, b, t});
    names.push_back(nm);
  endtask

  initial begin : monitor
    logic [7:0] exp_v, got_v;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_v = sb.pop_front();
        nm    = names.pop_front();
        got_v = {gnt, gnt_idx, busy, timeout};
        checks++;
        if (got_v !== exp_v)  begin
          failures++;
          $display("FAIL %s: got gnt=%b idx=%0d busy=%b to=%b, expected gnt=%b idx=%0d busy=%b to=%b",
                   nm, got_v[7:4], got_v[3:2], got_v[1], got_v[0],
                   exp_v[7:4], exp_v[3:2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  initial begin : stimulus
    // Reset held with all requests up, then first grant
    step("rst0",   1, 4'b1111, 0, 4'b0000, 0, 0, 0);
    step("rst1",   1, 4'b1111, 0, 4'b0000, 0, 0, 0);
    step("first",  0, 4'b1111, 0, 4'b0001, 0, 1, 0);
    // Rotation with release in every grant's first cycle
    step("rot1",   0, 4'b1111, 1, 4'b0010, 1, 1, 0);
    step("rot2",   0, 4'b1111, 1, 4'b0100, 2, 1, 0);
    step("rot3",   0, 4'b1111, 1, 4'b1000, 3, 1, 0);
    step("rot0",   0, 4'b1111, 1, 4'b0001, 0, 1, 0);
    step("to3",    0, 4'b1000, 1, 4'b1000, 3, 1, 0);
    step("idle_a", 0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    // Hold limit: owner 0 keeps grant for 8 cycles, then revoked
    step("hold1",  0, 4'b0101, 0, 4'b0001, 0, 1, 0);
    for (int k = 0; k < 7; k++) step("hold",  0, 4'b0101, 0, 4'b0001, 0, 1, 0);
    step("revoke", 0, 4'b0101, 0, 4'b0100, 2, 1, 1);
    // Release in the limit cycle beats the timeout
    for (int k = 0; k < 7; k++) step("hold2", 0, 4'b0101, 0, 4'b0100, 2, 1, 0);
    step("rel_lim",0, 4'b0101, 1, 4'b0001, 0, 1, 0);
    // Sole requester 3, re-granted, pointer wraps to 0
    step("drop0",  0, 4'b1000, 0, 4'b1000, 3, 1, 0);
    step("sole2",  0, 4'b1000, 0, 4'b1000, 3, 1, 0);
    step("sole3",  0, 4'b1000, 0, 4'b1000, 3, 1, 0);
    step("regrant",0, 4'b1000, 1, 4'b1000, 3, 1, 0);
    step("idle_b", 0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    step("wrap",   0, 4'b0110, 0, 4'b0010, 1, 1, 0);
    step("idle_c", 0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    // Reset during the 4th cycle of a grant to index 2
    step("g2_1",   0, 4'b0100, 0, 4'b0100, 2, 1, 0);
    for (int k = 0; k < 3; k++) step("g2_n", 0, 4'b0100, 0, 4'b0100, 2, 1, 0);
    step("rst_mid",1, 4'b0100, 0, 4'b0000, 0, 0, 0);
    step("ptr_rst",0, 4'b0110, 0, 4'b0010, 1, 1, 0);
    step("idle_d", 0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    step("rel_idl",0, 4'b0000, 1, 4'b0000, 0, 0, 0);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
